// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared SRAM request/response types, widths, FSM states and port indices
package sram_arbiter_pkg;

  localparam int SRAM_AW = 32;
  localparam int SRAM_DW = 64;
  localparam int SRAM_MW = SRAM_DW / 8;

  localparam logic ARB_PORT_IF = 1'b0;
  localparam logic ARB_PORT_LS = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } ArbState_e;

  typedef struct packed {
    logic               valid;
    logic               wen;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic [SRAM_MW-1:0] wmask;
  } SramReq_t;

  typedef struct packed {
    logic               ready;
    logic               rvalid;
    logic [SRAM_DW-1:0] rdata;
  } SramRsp_t;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational two-way grant picker; SRAM_ARB_RR_EN selects round-robin ties
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
`ifdef SRAM_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic [1:0] grant_o
);

  // A lone requester always wins; only the tie case depends on the build.
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
      // Grant whichever port did not win the previous accept.
      grant_o = (last_i == ARB_PORT_IF) ? 2'b10 : 2'b01;
`else
      // Load/store port has fixed priority over instruction fetch.
      grant_o = 2'b10;
`endif
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port SRAM arbiter with one outstanding transaction (SRAM_ARB_RR_EN: round-robin ties)
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW,
  parameter int MW = DW / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          iReq_valid,
  input  logic [1:0]          iReq_wen,
  input  logic [1:0][AW-1:0]  iReq_addr,
  input  logic [1:0][DW-1:0]  iReq_wdata,
  input  logic [1:0][MW-1:0]  iReq_wmask,
  output logic [1:0]          oReq_ready,
  output logic [1:0]          oRsp_valid,
  output logic [DW-1:0]       oRsp_rdata,
  output SramReq_t            oReq_SRAM,
  input  SramRsp_t            iRsp_SRAM
);

  ArbState_e     state_q, state_d;
  SramReq_t      req_q, req_d;
  logic          owner_q, owner_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    grant;
  logic          win;

`ifdef SRAM_ARB_RR_EN
  logic          last_q, last_d;

  sram_arb_pick u_pick (
    .valid_i (iReq_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );
`else
  sram_arb_pick u_pick (
    .valid_i (iReq_valid),
    .grant_o (grant)
  );
`endif

  assign win = grant[ARB_PORT_LS];

  // Next-state: accept in IDLE, replay in ISSUE, collect completion in WAIT.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    owner_d     = owner_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant != 2'b00) begin
          req_d.valid = 1'b1;
          req_d.wen   = iReq_wen[win];
          req_d.addr  = iReq_addr[win];
          req_d.wdata = iReq_wdata[win];
          req_d.wmask = iReq_wmask[win];
          owner_d     = win;
`ifdef SRAM_ARB_RR_EN
          last_d      = win;
`endif
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (iRsp_SRAM.ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (iRsp_SRAM.rvalid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = req_q.wen ? '0 : iRsp_SRAM.rdata;
          state_d              = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and captured request; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      req_q       <= '0;
      owner_q     <= ARB_PORT_IF;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q      <= ARB_PORT_LS;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Accept pulse is combinational and masked while reset is held.
  always_comb begin
    oReq_ready = 2'b00;
    if (!rst && state_q == ARB_IDLE) oReq_ready = grant;
  end

  // Downstream request is only driven in ISSUE, straight from the captured copy.
  always_comb begin
    oReq_SRAM = '0;
    if (state_q == ARB_ISSUE) oReq_SRAM = req_q;
  end

  assign oRsp_valid = rsp_valid_q;
  assign oRsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking scoreboard bench for sram_arbiter
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_wen;
  logic [1:0][31:0] req_addr;
  logic [1:0][63:0] req_wdata;
  logic [1:0][7:0]  req_wmask;
  logic [1:0]       rdy;
  logic [1:0]       rsp_valid;
  logic [63:0]      rsp_rdata;
  SramReq_t         sram_req;
  SramRsp_t         sram_rsp;

  sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .iReq_valid (req_valid),
    .iReq_wen   (req_wen),
    .iReq_addr  (req_addr),
    .iReq_wdata (req_wdata),
    .iReq_wmask (req_wmask),
    .oReq_ready (rdy),
    .oRsp_valid (rsp_valid),
    .oRsp_rdata (rsp_rdata),
    .oReq_SRAM  (sram_req),
    .iRsp_SRAM  (sram_rsp)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: automatic responder or manual override
  logic        auto_en = 1'b1;
  logic        a_ready = 1'b0, a_rvalid = 1'b0;
  logic [63:0] a_rdata = '0;
  logic        man_ready = 1'b0, man_rvalid = 1'b0;
  logic [63:0] man_rdata = '0;
  logic        pending = 1'b0;
  logic [63:0] pend_data = '0;
  int          wait_cnt = 0;
  int          stall = 0;
  logic [63:0] rdata_val = '0;
  SramReq_t    seen_req = '0;
  int          seen_cyc = -1;

  always_comb begin
    sram_rsp        = '0;
    sram_rsp.ready  = auto_en ? a_ready  : man_ready;
    sram_rsp.rvalid = auto_en ? a_rvalid : man_rvalid;
    sram_rsp.rdata  = auto_en ? a_rdata  : man_rdata;
  end

  initial forever begin
    @(posedge clk);
    #1;
    a_ready  = 1'b0;
    a_rvalid = 1'b0;
    if (rst || !auto_en) begin
      pending  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (pending) begin
        a_rvalid = 1'b1;
        a_rdata  = pend_data;
        pending  = 1'b0;
      end
      if (sram_req.valid) begin
        if (wait_cnt < stall) wait_cnt++;
        else begin
          a_ready   = 1'b1;
          pending   = 1'b1;
          pend_data = rdata_val;
          wait_cnt  = 0;
          seen_req  = sram_req;
          seen_cyc  = cyc;
        end
      end
    end
  end

  typedef struct {
    logic        port;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = -1, rsp_cyc = -1, acc_cnt = 0, rsp_cnt = 0;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Sample at negedge: push expectations on accept, pop and compare on completion
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (rdy != 2'b00) begin
        e.port = rdy[1];
        e.data = req_wen[e.port] ? 64'd0 : rdata_val;
        sb.push_back(e);
        grant_log.push_back(int'(e.port));
        acc_cyc = cyc;
        acc_cnt++;
      end
      if (rsp_valid != 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: oRsp_valid=%b with nothing outstanding, required 00", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (e.port ? 2'b10 : 2'b01) || rsp_rdata !== e.data) begin
            errors++;
            $display("FAIL rsp_data: valid=%b rdata=%h required valid=%b rdata=%h",
                     rsp_valid, rsp_rdata, (e.port ? 2'b10 : 2'b01), e.data);
          end
        end
        rsp_cyc = cyc;
        rsp_cnt++;
      end
    end
  endtask

  task automatic issue(input logic port, input logic wen, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask,
                       output bit ok, output int acc_at);
    next_cycle();
    req_wen[port]   = wen;
    req_addr[port]  = addr;
    req_wdata[port] = wdata;
    req_wmask[port] = wmask;
    req_valid[port] = 1'b1;
    ok = 1'b0;
    acc_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rdy[port]) begin
        ok = 1'b1;
        acc_at = cyc;
        break;
      end
      next_cycle();
    end
    next_cycle();
    req_valid[port] = 1'b0;
    tick();
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b01;
    req_wen = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    tick();
    checks += 4;
    if (rdy !== 2'b00) begin errors++; $display("FAIL reset_ready: %b required 00", rdy); end
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: %b required 00", rsp_valid); end
    if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: %h required 0", rsp_rdata); end
    if (sram_req !== '0) begin errors++; $display("FAIL reset_sram_req: %h required 0", sram_req); end
    next_cycle();
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_single_read();
    bit ok; int acc;
    rdata_val = 64'hDEAD_BEEF;
    issue(1'b0, 1'b0, 32'h80, 64'd0, 8'hFF, ok, acc);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_accept: not accepted, required accept within 20 cycles"); end
    wait_rsp(1, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL read_rsp_timeout: no completion, required one"); end
    if (rsp_cyc - acc != 3) begin errors++; $display("FAIL read_latency: %0d required 3", rsp_cyc - acc); end
    if (seen_cyc - acc != 1) begin errors++; $display("FAIL read_issue_cycle: %0d required 1", seen_cyc - acc); end
    if (seen_req.addr !== 32'h80 || seen_req.wen !== 1'b0) begin
      errors++; $display("FAIL read_sram_fields: addr=%h wen=%b required addr=80 wen=0", seen_req.addr, seen_req.wen);
    end
    next_cycle();
    tick();
    checks++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL read_pulse_hold: valid=%b rdata=%h required 00 deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_write();
    bit ok; int acc;
    rdata_val = 64'h5555_5555;
    issue(1'b1, 1'b1, 32'h100, 64'h1122, 8'h0F, ok, acc);
    wait_rsp(2, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL write_rsp_timeout: no completion, required one"); end
    if (seen_req.wen !== 1'b1 || seen_req.wmask !== 8'h0F || seen_req.wdata !== 64'h1122) begin
      errors++; $display("FAIL write_sram_fields: wen=%b mask=%h data=%h required 1 0f 1122",
                         seen_req.wen, seen_req.wmask, seen_req.wdata);
    end
  endtask

  task automatic test_tie();
    bit ok; int base; int expv[4];
`ifdef SRAM_ARB_RR_EN
    expv = '{0, 1, 0, 1};
`else
    expv = '{1, 1, 1, 1};
`endif
    rdata_val = 64'h0123_4567_89AB_CDEF;
    base = rsp_cnt;
    grant_log.delete();
    next_cycle();
    req_wen = 2'b00;
    req_addr[0] = 32'h40; req_addr[1] = 32'h44;
    req_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant_log.size() >= 4) break;
      next_cycle();
    end
    next_cycle();
    req_valid = 2'b00;
    tick();
    checks++;
    if (grant_log.size() < 4) begin
      errors++; $display("FAIL tie_count: %0d grants required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != expv[i]) begin
          errors++; $display("FAIL tie_order[%0d]: port %0d required %0d", i, grant_log[i], expv[i]);
        end
      end
    end
    wait_rsp(base + 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tie_rsp_timeout: completions missing, required 4"); end
  endtask

  task automatic test_backpressure();
    bit ok; int acc; SramReq_t expq;
    expq = '{valid: 1'b1, wen: 1'b0, addr: 32'h200, wdata: 64'hAAAA, wmask: 8'hF0};
    rdata_val = 64'hFEED_0000_0000_0042;
    stall = 5;
    issue(1'b0, 1'b0, 32'h200, 64'hAAAA, 8'hF0, ok, acc);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin next_cycle(); tick(); end
      checks++;
      if (sram_req !== expq) begin
        errors++; $display("FAIL bp_stable[%0d]: %h required %h", i, sram_req, expq);
      end
    end
    wait_rsp(rsp_cnt + 1, ok);
    checks++;
    if (!ok || rsp_cyc - acc != 8) begin
      errors++; $display("FAIL bp_latency: ok=%0d latency=%0d required 8", ok, rsp_cyc - acc);
    end
    stall = 0;
  endtask

  task automatic test_back_to_back();
    bit ok; int acc; int n;
    rdata_val = 64'h77;
    n = acc_cnt;
    issue(1'b0, 1'b0, 32'h500, 64'd0, 8'hFF, ok, acc);
    next_cycle();
    tick();
    next_cycle();
    req_addr[0] = 32'h508;
    req_valid[0] = 1'b1;
    tick();
    checks += 2;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL b2b_rsp: %b required 01", rsp_valid); end
    if (rdy !== 2'b01 || acc_cnt != n + 2) begin
      errors++; $display("FAIL b2b_accept: ready=%b accepts=%0d required 01 %0d", rdy, acc_cnt - n, 2);
    end
    acc = cyc;
    next_cycle();
    req_valid[0] = 1'b0;
    tick();
    wait_rsp(rsp_cnt + 1, ok);
    checks++;
    if (!ok || rsp_cyc - acc != 3) begin
      errors++; $display("FAIL b2b_second: ok=%0d latency=%0d required 3", ok, rsp_cyc - acc);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok; int acc;
    auto_en = 1'b0;
    issue(1'b0, 1'b0, 32'h400, 64'd0, 8'hFF, ok, acc);
    next_cycle();
    man_ready = 1'b1;
    tick();
    next_cycle();
    man_ready = 1'b0;
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    checks += 4;
    if (rdy !== 2'b00) begin errors++; $display("FAIL rstw_ready: %b required 00", rdy); end
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstw_rsp_valid: %b required 00", rsp_valid); end
    if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL rstw_rdata: %h required 0", rsp_rdata); end
    if (sram_req !== '0) begin errors++; $display("FAIL rstw_sram_req: %h required 0", sram_req); end
    sb.delete();
    next_cycle();
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
    next_cycle();
    man_rvalid = 1'b1;
    man_rdata = 64'hBAD;
    tick();
    next_cycle();
    man_rvalid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tick();
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstw_late_rvalid[%0d]: %b required 00", i, rsp_valid); end
    end
    auto_en = 1'b1;
    rdata_val = 64'hC0FFEE;
    issue(1'b1, 1'b0, 32'h600, 64'd0, 8'hFF, ok, acc);
    wait_rsp(rsp_cnt + 1, ok);
    checks++;
    if (!ok || rsp_cyc - acc != 3) begin
      errors++; $display("FAIL rstw_recover: ok=%0d latency=%0d required 3", ok, rsp_cyc - acc);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d outstanding required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
